// File: rtl/aes_pkg.sv
// Shared AES definitions for the key schedule and the encryption datapath.
//   state_t    : key-expansion FSM states
//   NR, KW     : AES-128 round count and key/round-key width
//   RCON_INIT  : first round constant
//   xtime()    : multiply a byte by x in GF(2^8)
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    READY
  } state_t;

  localparam int NR = 10;
  localparam int KW = 128;

  localparam logic [7:0] RCON_INIT = 8'h01;

  // Shift left; reduce by the AES polynomial when the MSB falls off.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box.
//   din  : input byte
//   dout : substituted byte
module aes_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign dout = SBOX[din];

endmodule

// File: rtl/aes_key_expand_seq.sv
// Sequential AES-128 key schedule: derives RK0..RK10 one per clock after a
// key is accepted, holds them in an 11x128 register file, and serves them by
// index with a one-cycle registered read.
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   key_valid  : accept key_in on this edge (ignored while expanding)
//   key_in     : cipher key, byte 0 in bits [127:120]
//   busy       : expansion in progress
//   keys_ready : all round keys valid; cleared by the next accepted key
//   rk_idx     : round-key index to read (11..15 read as zero)
//   rk_out     : RK[rk_idx] from the previous edge
module aes_key_expand_seq
  import aes_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          key_valid,
  input  logic [KW-1:0] key_in,
  output logic          busy,
  output logic          keys_ready,
  input  logic [3:0]    rk_idx,
  output logic [KW-1:0] rk_out
);

  state_t        state;
  logic [KW-1:0] w;
  logic [3:0]    round;
  logic [7:0]    rcon;
  logic [KW-1:0] rk [NR+1];

  logic [31:0]   rot_word;
  logic [31:0]   sub_word;
  logic [31:0]   temp;
  logic [KW-1:0] w_next;

  // RotWord: cyclic byte rotate left of the last word.
  assign rot_word = {w[23:0], w[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .din  (rot_word[8*i +: 8]),
      .dout (sub_word[8*i +: 8])
    );
  end

  // Each new word chains off the previously computed one.
  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    temp           = sub_word ^ {rcon, 24'h0};
    w_next         = '0;
    w_next[127:96] = w[127:96] ^ temp;
    w_next[95:64]  = w[95:64]  ^ w_next[127:96];
    w_next[63:32]  = w[63:32]  ^ w_next[95:64];
    w_next[31:0]   = w[31:0]   ^ w_next[63:32];
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values;
  // this also gives the read port its read-before-write behaviour.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      keys_ready <= 1'b0;
      rk_out     <= '0;
      w          <= '0;
      round      <= 4'd0;
      rcon       <= RCON_INIT;
      // NOTE: the key file is cleared on reset so stale keys never leak out
      // after an abort; it is small enough to live in flops.
      for (int i = 0; i <= NR; i++) rk[i] <= '0;
    end else begin
      rk_out <= (rk_idx <= 4'(NR)) ? rk[rk_idx] : '0;

      case (state)
        IDLE, READY: begin
          if (key_valid) begin
            rk[0]      <= key_in;
            w          <= key_in;
            round      <= 4'd1;
            rcon       <= RCON_INIT;
            state      <= EXPAND;
            busy       <= 1'b1;
            keys_ready <= 1'b0;
          end
        end
        EXPAND: begin
          rk[round] <= w_next;
          w         <= w_next;
          round     <= round + 4'd1;
          rcon      <= xtime(rcon);
          if (round == 4'(NR)) begin
            state      <= READY;
            busy       <= 1'b0;
            keys_ready <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Testbench for aes_key_expand_seq: directed FIPS-197 key vectors, a read
// scoreboard checked by an independent monitor, and direct status checks.
module tb_aes_key_expand_seq;

  logic         clk;
  logic         rst;
  logic         key_valid;
  logic [127:0] key_in;
  logic         busy;
  logic         keys_ready;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;

  logic         rd_issue;
  logic [127:0] exp_q  [$];
  string        name_q [$];

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] KEY_A    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY_A_10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] KEY_B    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_B_1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] KEY_B_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KEY_Z    = 128'h0;
  localparam logic [127:0] KEY_Z_1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] KEY_Z_10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  aes_key_expand_seq dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_in     (key_in),
    .busy       (busy),
    .keys_ready (keys_ready),
    .rk_idx     (rk_idx),
    .rk_out     (rk_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a read issued before an edge is answered by rk_out just after it.
  initial begin
    forever begin
      @(posedge clk);
      if (rd_issue) begin
        #1;
        if (exp_q.size() == 0) begin
          check("unexpected_read", rk_out, 128'hx);
        end else begin
          check(name_q.pop_front(), rk_out, exp_q.pop_front());
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
  endtask

  task automatic start_key(input logic [127:0] k);
    key_valid = 1'b1;
    key_in    = k;
    cycles(1);
    key_valid = 1'b0;
  endtask

  task automatic read(input logic [3:0] idx, input logic [127:0] exp, input string name);
    rk_idx   = idx;
    rd_issue = 1'b1;
    exp_q.push_back(exp);
    name_q.push_back(name);
    cycles(1);
    rd_issue = 1'b0;
  endtask

  // Counts edges until keys_ready, and how many sampled cycles had busy high.
  task automatic wait_ready(output int edges, output int busy_cycles);
    edges       = 0;
    busy_cycles = 0;
    while (!keys_ready && edges < 30) begin
      if (busy) busy_cycles++;
      cycles(1);
      edges++;
    end
    if (!keys_ready) check("ready_timeout", 128'(keys_ready), 128'd1);
  endtask

  int edges;
  int bcyc;

  initial begin
    rst       = 1'b0;
    key_valid = 1'b0;
    key_in    = '0;
    rk_idx    = 4'd0;
    rd_issue  = 1'b0;
    cycles(1);

    do_reset();
    check("reset_busy", 128'(busy), 128'd0);
    check("reset_keys_ready", 128'(keys_ready), 128'd0);
    check("reset_rk_out", rk_out, 128'd0);

    // Key A: latency and busy width
    start_key(KEY_A);
    check("accept_busy", 128'(busy), 128'd1);
    check("accept_keys_ready", 128'(keys_ready), 128'd0);
    wait_ready(edges, bcyc);
    check("ready_latency", 128'(edges + 1), 128'd11);
    check("busy_cycles", 128'(bcyc), 128'd10);
    check("ready_busy_low", 128'(busy), 128'd0);
    read(4'd10, KEY_A_10, "a_rk10");

    // Second key during expansion is ignored
    start_key(KEY_A);
    cycles(3);
    start_key(KEY_B);
    wait_ready(edges, bcyc);
    check("ignored_latency", 128'(edges + 5), 128'd11);
    read(4'd10, KEY_A_10, "ignored_rk10");

    // New key from READY
    start_key(KEY_B);
    check("ready_restart_kr", 128'(keys_ready), 128'd0);
    check("ready_restart_busy", 128'(busy), 128'd1);
    wait_ready(edges, bcyc);
    read(4'd0, KEY_B, "b_rk0");
    read(4'd1, KEY_B_1, "b_rk1");
    read(4'd10, KEY_B_10, "b_rk10");
    read(4'd11, 128'h0, "b_rk11");
    read(4'd15, 128'h0, "b_rk15");
    read(4'd1, KEY_B_1, "stream_rk1");
    read(4'd0, KEY_B, "stream_rk0");
    read(4'd10, KEY_B_10, "stream_rk10");

    // Reset mid-expansion
    start_key(KEY_A);
    cycles(4);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    check("abort_busy", 128'(busy), 128'd0);
    check("abort_keys_ready", 128'(keys_ready), 128'd0);
    check("abort_rk_out", rk_out, 128'd0);
    read(4'd3, 128'h0, "abort_rk3");
    read(4'd0, 128'h0, "abort_rk0");
    cycles(3);
    check("abort_stays_idle", 128'(busy), 128'd0);

    // Zero key after abort
    start_key(KEY_Z);
    wait_ready(edges, bcyc);
    check("zero_latency", 128'(edges + 1), 128'd11);
    read(4'd1, KEY_Z_1, "z_rk1");
    read(4'd10, KEY_Z_10, "z_rk10");
    read(4'd0, KEY_Z, "z_rk0");

    cycles(2);
    check("scoreboard_drained", 128'(exp_q.size()), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes_key_expand_seq.md
Name: aes_key_expand_seq

Overview:
Sequential AES-128 key schedule that sits directly upstream of the AES encryption datapath.
- Accepts one 128-bit cipher key and iteratively derives round keys RK0..RK10, one per clock.
- Stores all 11 round keys in an internal register file.
- Serves them by round index with registered-read timing, so the encryption core can pull RK[n] while executing round n.

Parameters:
- NR, 10, number of AES rounds. Fixed at 10 for AES-128; any other value is unsupported.
- KW, 128, key and round-key width in bits.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- key_valid  input  1  request pulse; key_in is sampled on the same edge.
- key_in  input  128  cipher key; bits [127:120] are byte 0 (FIPS-197 order).
- busy  output  1  high while expansion is in progress.
- keys_ready  output  1  high when RK0..RK10 are valid; stays high until the next accepted key or reset.
- rk_idx  input  4  round-key index to read, 0..10.
- rk_out  output  128  registered RK[rk_idx]; 1-cycle read latency.

Behaviour:
- Reset (rst=1 at an edge):
  - state<=IDLE; busy=0, keys_ready=0, rk_out=0.
  - Round counter=0, rcon=8'h01.
  - Register file cleared to 0.
  - Reset overrides every other input on the same edge.
- FSM states: IDLE, EXPAND, READY.
- IDLE or READY with key_valid=1:
  - rk[0]<=key_in, working word W<=key_in.
  - round<=1, rcon<=8'h01.
  - state<=EXPAND, busy<=1, keys_ready<=0.
- EXPAND, each edge:
  - temp = SubWord(RotWord(W[31:0])) ^ {rcon,24'h0}.
  - w0'=W[127:96]^temp, w1'=W[95:64]^w0', w2'=W[63:32]^w1', w3'=W[31:0]^w2'.
  - rk[round]<=W'; W<=W'; round<=round+1.
  - rcon<=xtime(rcon): shift left 1, XOR 8'h1B if the MSB was set. Sequence is 01,02,04,08,10,20,40,80,1B,36.
- Leaving EXPAND: on the edge that writes rk[10], state<=READY, busy<=0, keys_ready<=1.
  - Timing: keys_ready is high 11 edges after the accepting edge (1 load edge + 10 expand edges).
- key_valid while in EXPAND: ignored. No restart, no queuing. The caller must wait for busy=0.
- key_valid in READY: starts a new expansion. keys_ready drops on the accepting edge. Old register contents stay readable during expansion but are undefined for use.
- Read port:
  - rk_out<=rk[rk_idx] on every edge, in any state.
  - rk_idx 11..15 gives rk_out<=128'h0.
  - A read of an index written on the same edge returns the old value (read-before-write).
- Reset mid-EXPAND: aborts to IDLE with all outputs at their reset values. A fresh key_valid is required.
- All XOR/rcon arithmetic is GF(2^8) byte-wise. There is no carry anywhere.

Decomposition:
- Shared package aes_pkg holds:
  - state enum {IDLE, EXPAND, READY};
  - constants NR=10, KW=128;
  - function xtime(byte);
  - rcon initial value 8'h01.
- One natural sub-module: aes_sbox, a combinational 8-bit S-box already used by the encryption datapath.
  - Instantiated 4x for SubWord.
- The register file (11x128) and FSM live in the top block.

Test Plan:
- Key 000102030405060708090a0b0c0d0e0f:
  - busy high for exactly 10 cycles; keys_ready high 11 edges after accept.
  - rk_idx=10 -> rk_out=13111d7fe3944a17f307a78b4d2b30c5 one cycle later.
- Key 2b7e151628aed2a6abf7158809cf4f3c:
  - rk_idx=0 -> 2b7e151628aed2a6abf7158809cf4f3c.
  - rk_idx=1 -> a0fafe1788542cb123a339392a6c7605.
  - rk_idx=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
- All-zero key:
  - rk_idx=1 -> 62636363626363636263636362636363.
  - rk_idx=10 -> b4ef5bcb3e92e21123e951cf6f8f188e.
- Second key_valid asserted at expansion cycle 4 with a different key:
  - Ignored; final RK10 matches the first key.
  - Then key_valid in READY with the new key -> keys_ready drops, then RK10 matches the new key.
- rst=1 at expansion cycle 5:
  - Next cycle busy=0, keys_ready=0, rk_out=0.
  - rk_idx=3 reads 0.
  - New key then expands correctly.
- rk_idx=11 and rk_idx=15 in READY -> rk_out=0. Switching rk_idx each cycle gives a 1-cycle-latency output stream.
